seq_relop_unit: RTL
===================

Name: seq_relop_unit

Overview:
- Parametrised, multi-cycle relational-operator engine; successor to the single-bit combinational ==, !=, >, >=, <, <= compares.
- Compares two WIDTH-bit operands MSB-first, CHUNK bits per cycle, and terminates early at the first differing chunk.
- Supports signed and unsigned operands and a runtime-selectable operator.
- Has valid/ready handshakes on both sides and sits between operand staging and a result consumer in the synthesis test datapath.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK, WIDTH/CHUNK, derived; not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand/op request valid
- in_ready  output  1  block can accept a request
- in_a  input  WIDTH  left operand
- in_b  input  WIDTH  right operand
- in_op  input  3  0:==  1:!=  2:>  3:>=  4:<  5:<=  6,7: illegal
- in_signed  input  1  1 = two's-complement compare
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_result  output  1  a OP b
- out_eq  output  1  a == b
- out_lt  output  1  a < b (per in_signed)
- out_err  output  1  illegal op code captured
- out_cycles  output  $clog2(NCHUNK)+1  number of chunks examined

Behaviour:
- Clock and reset: one clock domain, clk; rst is synchronous, active-high, sampled on the rising edge.
- Reset:
  - State goes to IDLE.
  - in_ready=1; out_valid=0.
  - out_result, out_eq, out_lt and out_err are 0; out_cycles=0.
  - Chunk index is cleared.
- Reset mid-operation: an in-flight compare is discarded and no out_valid is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture in_a, in_b, in_op and in_signed into registers, set k=0 (k=0 is the MSB chunk), go to RUN.
- RUN:
  - in_ready=0. Compare chunk k, i.e. bits [WIDTH-1-k*CHUNK -: CHUNK], of both operands.
  - Chunk k=0 with signed=1 is compared as signed; every other chunk is compared unsigned.
  - Chunks differ: latch lt/gt from that chunk, eq=0, go to DONE.
  - Chunks equal and k==NCHUNK-1: eq=1, lt=0, go to DONE.
  - Chunks equal otherwise: k<=k+1, stay in RUN.
  - out_cycles records k+1 at the deciding chunk.
- Latency:
  - out_valid rises on the edge after the deciding chunk.
  - Accept edge to out_valid = (index of first differing chunk, 1-based) + 1 cycles, or NCHUNK+1 if the operands are equal.
  - Maximum latency is NCHUNK+1 cycles; minimum is 2.
- DONE:
  - out_valid=1; all out_* are stable until handshake.
  - out_result is decoded from eq/lt per the captured op.
  - Illegal op: out_result=0, out_err=1; the compare still runs and out_eq/out_lt are valid.
  - out_valid && out_ready: go to IDLE; out_valid drops on the next edge.
  - Backpressure (out_ready=0) holds DONE indefinitely with outputs frozen.
- No new request is accepted until the result has handshaken; there is no pipelining or overlap. in_ready is 1 only in IDLE.
- in_valid is ignored outside IDLE, and input changes after the accept edge have no effect.
- CHUNK==WIDTH degenerates to a single-cycle RUN (latency 2).
- Signed extremes:
  - 0x80000000 < 0x7FFFFFFF when signed; the reverse holds when unsigned.
  - The decision is made in chunk 0.

Test Plan (WIDTH=32, CHUNK=8):
- Equal operands: a=b=0x12345678, op=0, unsigned
  - -> out_valid 5 cycles after accept; out_result=1, out_eq=1, out_lt=0, out_cycles=4.
- Early exit: a=0x20000000, b=0x10FFFFFF, op=2 (>)
  - -> out_valid 2 cycles after accept; out_result=1, out_lt=0, out_cycles=1.
- Signed vs unsigned: a=0x80000000, b=0x7FFFFFFF, op=4 (<)
  - signed=1 -> out_result=1, out_lt=1.
  - signed=0 -> out_result=0, out_lt=0.
  - Both cases: out_cycles=1.
- Last-chunk decision and all ops: a=0x000000FE, b=0x000000FF
  - Sweep ops 0..5 -> results 0,1,0,0,1,1; out_cycles=4.
  - Ops 6 and 7 -> out_result=0, out_err=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid
  - -> outputs frozen, in_ready=0, in_valid pulses ignored.
  - Release -> one handshake; in_ready=1 the following cycle.
- Reset mid-RUN: assert rst during chunk 2 of an equal compare
  - -> next cycle in_ready=1, out_valid=0, all outputs 0.
  - No result is emitted; a fresh request then completes normally.

Source files
------------

// File: rtl/seq_relop_unit.sv
// Multi-cycle relational compare: walks two WIDTH-bit operands MSB-first, CHUNK bits
// per cycle, stops at the first differing chunk and reports a OP b plus eq/lt flags.
module seq_relop_unit #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [WIDTH-1:0]                      in_a,
   input  logic [WIDTH-1:0]                      in_b,
   input  logic [2:0]                            in_op,
   input  logic                                  in_signed,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic                                  out_result,
   output logic                                  out_eq,
   output logic                                  out_lt,
   output logic                                  out_err,
   output logic [$clog2(WIDTH/CHUNK):0]          out_cycles
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int CW     = $clog2(NCHUNK) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
   logic [2:0]        op_q, op_d;
   logic              signed_q, signed_d;
   logic [KW-1:0]     k_q, k_d;
   logic              eq_q, eq_d, lt_q, lt_d;
   logic              result_q, result_d, err_q, err_d;
   logic [CW-1:0]     cycles_q, cycles_d;

   logic [CHUNK-1:0]  chunk_a [NCHUNK];
   logic [CHUNK-1:0]  chunk_b [NCHUNK];
   logic [CHUNK-1:0]  sign_flip, cmp_a, cmp_b;
   logic              chunk_eq, chunk_lt, last_chunk;
   logic              op_res, op_err;

   genvar gi;
   generate
      for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
         assign chunk_a[gi] = a_q[WIDTH-1-gi*CHUNK -: CHUNK];
         assign chunk_b[gi] = b_q[WIDTH-1-gi*CHUNK -: CHUNK];
      end
   endgenerate

   // Flipping the top bit of the MSB chunk turns a signed compare into an unsigned one.
   always_comb begin
      sign_flip            = '0;
      sign_flip[CHUNK-1]   = signed_q && (k_q == '0);
      cmp_a                = chunk_a[k_q] ^ sign_flip;
      cmp_b                = chunk_b[k_q] ^ sign_flip;
      chunk_eq             = (cmp_a == cmp_b);
      chunk_lt             = (cmp_a < cmp_b);
      last_chunk           = (k_q == KW'(NCHUNK - 1));
   end

   always_comb begin
      op_res = 1'b0;
      op_err = 1'b0;
      case (op_q)
         3'd0:    op_res = chunk_eq;
         3'd1:    op_res = !chunk_eq;
         3'd2:    op_res = !chunk_eq && !chunk_lt;
         3'd3:    op_res = !chunk_lt;
         3'd4:    op_res = chunk_lt;
         3'd5:    op_res = chunk_lt || chunk_eq;
         default: op_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      signed_d = signed_q;
      k_d      = k_q;
      eq_d     = eq_q;
      lt_d     = lt_q;
      result_d = result_q;
      err_d    = err_q;
      cycles_d = cycles_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d      = in_a;
               b_d      = in_b;
               op_d     = in_op;
               signed_d = in_signed;
               k_d      = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (!chunk_eq || last_chunk) begin
               eq_d     = chunk_eq;
               lt_d     = chunk_lt;
               result_d = op_res;
               err_d    = op_err;
               cycles_d = CW'(k_q) + CW'(1);
               state_d  = DONE;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         signed_q <= 1'b0;
         k_q      <= '0;
         eq_q     <= 1'b0;
         lt_q     <= 1'b0;
         result_q <= 1'b0;
         err_q    <= 1'b0;
         cycles_q <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         signed_q <= signed_d;
         k_q      <= k_d;
         eq_q     <= eq_d;
         lt_q     <= lt_d;
         result_q <= result_d;
         err_q    <= err_d;
         cycles_q <= cycles_d;
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign out_result = result_q;
   assign out_eq     = eq_q;
   assign out_lt     = lt_q;
   assign out_err    = err_q;
   assign out_cycles = cycles_q;
endmodule
